// File: rtl/instr_feeder_pkg.sv
// instr_feeder_pkg: constants and types shared by the instruction feeder and the decoder.
package instr_feeder_pkg;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  typedef enum logic {STREAM, REPLAY} mode_e;
  function automatic logic [5:0] opcode(input logic [31:0] w);
    return w[OP_HI:OP_LO];
  endfunction
endpackage

// File: rtl/feeder_ram.sv
// feeder_ram: DEPTH x DATA_W storage, one synchronous write port, one asynchronous read port.
module feeder_ram
  import instr_feeder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_feeder.sv
// instr_feeder: loadable instruction queue issuing one word per clock, NOPs when idle.
// Define INSTR_FEEDER_LOOP_EN to add the loop port and program replay.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     stall,
`ifdef INSTR_FEEDER_LOOP_EN
  input  logic                     loop,
`endif
  input  logic                     wr_valid,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  output logic [DATA_W-1:0]        instr_out,
  output logic                     instr_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic [CNT_W-1:0]         issued_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] head, tail, head_n, rd_addr;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] rd_data;
  logic slot, have, push, pop;
  mode_e mode;
  assign count = cnt;
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
  assign wr_ready = !full && mode == STREAM;
  assign slot = enable && !stall;
  assign have = !empty;
  assign push = wr_valid && wr_ready;
  assign pop = slot && have && mode == STREAM;
  assign head_n = pop ? head + AW'(1) : head;
`ifdef INSTR_FEEDER_LOOP_EN
  logic [AW-1:0] cursor;
  assign mode = loop ? REPLAY : STREAM;
  assign rd_addr = mode == REPLAY ? cursor : head;
  // Outside replay the cursor shadows head, so dropping loop resumes from the oldest entry.
  always_ff @(posedge clk)
    if (!rst_n) cursor <= '0;
    else if (mode == STREAM) cursor <= head_n;
    else if (slot && have) cursor <= cursor + AW'(1) == tail ? head : cursor + AW'(1);
`else
  assign mode = STREAM;
  assign rd_addr = head;
`endif
  feeder_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(push),
    .waddr(tail),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      instr_out <= DATA_W'(NOP_WORD);
      instr_valid <= 1'b0;
      issued_cnt <= '0;
    end else begin
      head <= head_n;
      if (push) tail <= tail + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (!enable) begin
        instr_out <= DATA_W'(NOP_WORD);
        instr_valid <= 1'b0;
      end else if (!stall) begin
        instr_out <= have ? rd_data : DATA_W'(NOP_WORD);
        instr_valid <= have;
        if (have && issued_cnt != '1) issued_cnt <= issued_cnt + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_instr_feeder.sv
// tb_instr_feeder: vector table plus queue-model scoreboard for instr_feeder.
module tb_instr_feeder;
  localparam int DEPTH = 16;
  localparam int CNTW = 4;
  logic clk = 0, rst_n = 0, enable = 0, stall = 0, lp = 0, wr_valid = 0;
  logic [31:0] wr_data = 0;
  logic wr_ready, instr_valid, empty, full;
  logic [31:0] instr_out;
  logic [4:0] count;
  logic [CNTW-1:0] issued_cnt;
  logic [31:0] q[$];
  logic [31:0] m_out = 0;
  logic m_valid = 0;
  int m_iss = 0, cur = 0, total = 0, bad = 0, cyc = 0;
  bit known = 0;
  typedef struct {logic rst_n; logic en; logic wv; logic [31:0] wd; logic [31:0] eo; logic ev;} vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  instr_feeder #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(CNTW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .stall(stall),
`ifdef INSTR_FEEDER_LOOP_EN
    .loop(lp),
`endif
    .wr_valid(wr_valid),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .instr_out(instr_out),
    .instr_valid(instr_valid),
    .count(count),
    .empty(empty),
    .full(full),
    .issued_cnt(issued_cnt)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
    end
  endtask

  task automatic tick();
    bit acc;
    #1;
    if (known) chk("wr_ready", 32'(wr_ready), 32'(q.size() < DEPTH && !lp));
    acc = wr_valid && q.size() < DEPTH && !lp;
    if (!rst_n) begin
      q.delete();
      m_out = 0;
      m_valid = 0;
      m_iss = 0;
      cur = 0;
    end else begin
      if (!enable) begin
        m_out = 0;
        m_valid = 0;
      end else if (!stall) begin
        if (q.size() == 0) begin
          m_out = 0;
          m_valid = 0;
        end else begin
          m_valid = 1;
          m_iss = m_iss < 15 ? m_iss + 1 : 15;
          if (lp) begin
            m_out = q[cur];
            cur = cur + 1 == q.size() ? 0 : cur + 1;
          end else m_out = q.pop_front();
        end
      end
      if (!lp) cur = 0;
      if (acc) q.push_back(wr_data);
    end
    @(posedge clk);
    known = 1;
    cyc++;
    #1;
    chk("instr_out", instr_out, m_out);
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("issued_cnt", 32'(issued_cnt), 32'(m_iss));
  endtask

  task automatic push(input logic [31:0] w);
    wr_valid = 1;
    wr_data = w;
    tick();
    wr_valid = 0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h2001_0004, 32'h0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'h2002_0002, 32'h2001_0004, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h0022_001A, 32'h2002_0002, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h0062_1818, 32'h0022_001A, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h0061_2022, 32'h0062_1818, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0061_2022, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      rst_n = tbl[i].rst_n;
      enable = tbl[i].en;
      wr_valid = tbl[i].wv;
      wr_data = tbl[i].wd;
      tick();
      chk("tbl_out", instr_out, tbl[i].eo);
      chk("tbl_valid", 32'(instr_valid), 32'(tbl[i].ev));
    end
    wr_valid = 0;
    chk("five_issued", 32'(issued_cnt), 32'd5);
    // fill to capacity with issue disabled, then a refused 17th push
    enable = 0;
    for (int i = 0; i < DEPTH; i++) push(32'hA000_0000 + 32'(i));
    chk("full_flag", 32'(full), 32'd1);
    push(32'hDEAD_BEEF);
    enable = 1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    chk("drained", 32'(count), 32'd0);
    // stall between two issues, with a write accepted during the stall
    push(32'h2001_0004);
    push(32'h2002_0002);
    stall = 1;
    tick();
    push(32'h0022_001A);
    chk("stall_hold", instr_out, 32'h2001_0004);
    stall = 0;
    for (int i = 0; i < 3; i++) tick();
`ifdef INSTR_FEEDER_LOOP_EN
    enable = 0;
    push(32'h1111_0001);
    push(32'h2222_0002);
    push(32'h3333_0003);
    lp = 1;
    enable = 1;
    for (int i = 0; i < 4; i++) tick();
    push(32'h4444_0004);
    for (int i = 0; i < 3; i++) tick();
    chk("loop_count", 32'(count), 32'd3);
    lp = 0;
    for (int i = 0; i < 5; i++) tick();
`endif
    // reset with words queued; none may ever issue afterwards
    enable = 0;
    for (int i = 0; i < 4; i++) push(32'hBAD0_0000 + 32'(i));
    rst_n = 0;
    tick();
    rst_n = 1;
    enable = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_nop", 32'(instr_valid), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_feeder.md
# instr_feeder

Parametrised, synthesizable instruction-issue buffer that sits in front of `processor_top.instr_in`. It replaces hand-timed per-cycle stimulus with a loadable program queue. A host, either a bench or a boot loader, pushes instruction words through a valid/ready port. The block issues one word per clock while `enable` is high and the pipeline is not stalled, inserts NOPs when it has nothing to issue, and can optionally replay the loaded program in a loop.

## Interface
- `DATA_W`, default 32: instruction word width.
- `DEPTH`, default 16: queue entries; must be a power of two, at least 2.
- `CNT_W`, default 16: width of the issue counter.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `enable`, input, 1: issue enable, same meaning as `processor_top.enable`.
- `stall`, input, 1: pipeline stall from the hazard unit; holds the output.
- `loop`, input, 1: replay mode select; only present when the loop feature is compiled in (see Configuration).
- `wr_valid`, input, 1: host presents a word.
- `wr_data`, input, DATA_W: instruction word from the host.
- `wr_ready`, output, 1: the block accepts a word this cycle.
- `instr_out`, output, DATA_W: connects to `processor_top.instr_in`.
- `instr_valid`, output, 1: `instr_out` is a real queued instruction, not a NOP.
- `count`, output, $clog2(DEPTH)+1: number of entries currently held.
- `empty`, output, 1: `count == 0`.
- `full`, output, 1: `count == DEPTH`.
- `issued_cnt`, output, CNT_W: number of valid issues since reset; saturates at all-ones.

## Operation
- Storage is a circular buffer with three pointers: `head` (oldest entry), `tail` (next write slot) and `cursor` (next entry to issue). All pointers wrap modulo DEPTH.
- A write is accepted when `wr_valid && wr_ready`. The word goes to `mem[tail]`, then `tail` increments.
- `wr_ready = !full`. It is forced low while loop mode is active.
- An issue slot occurs when `enable && !stall`.
- Issue slot with `count > 0`, stream mode:
  - `instr_out <= mem[head]`, `instr_valid <= 1`.
  - `head` and `cursor` increment; `count` decrements.
- Issue slot with `count == 0`: `instr_out <= NOP`, `instr_valid <= 0`.
- Loop mode (`loop == 1`, `count > 0`):
  - `instr_out <= mem[cursor]`, `instr_valid <= 1`; entries are not consumed and `count` is unchanged.
  - `cursor` advances. When `cursor + 1 == tail`, it wraps to `head` instead.
- `loop` falling edge: `cursor <= head` on the next edge; stream issue then resumes from the oldest entry.
- `stall` high with `enable` high: `instr_out` and `instr_valid` hold their values; pointers and `count` hold; writes are still accepted.
- `enable` low: `instr_out <= NOP`, `instr_valid <= 0`; pointers hold; writes are still accepted.
- Simultaneous write and stream pop: `count` is unchanged. The write and the pop target different slots except when `count == 0`; in that case the pop does not occur and the slot issues a NOP.
- `issued_cnt` increments on every edge that loads `instr_valid <= 1`. It holds at `2^CNT_W - 1` once saturated.

## Timing
- Reset values, applied on the first edge with `rst_n == 0`:
  - `instr_out = NOP` (32'h0000_0000), `instr_valid = 0`.
  - `count = 0`, `empty = 1`, `full = 0`, `wr_ready = 1`, `issued_cnt = 0`.
  - All pointers = 0. Memory contents are don't-care.
- Reset mid-operation discards all queued words. The first post-reset edge behaves as an idle cycle.
- `instr_out` and `instr_valid` are registered.
- Write-to-issue latency:
  - A word accepted at edge k into an empty queue appears on `instr_out` after edge k+1, provided edge k+1 is an issue slot.
- Throughput: one word per clock, sustained.
- `count`, `empty`, `full` and `wr_ready` are derived from registered state.
- `wr_ready` reflects the current cycle. It does not look ahead to a pop in the same cycle.

## Configuration
- `INSTR_FEEDER_LOOP_EN` defined:
  - The `loop` port, the `cursor` register and the replay behaviour exist as described.
- `INSTR_FEEDER_LOOP_EN` undefined:
  - The `loop` port is absent.
  - `cursor` is not instantiated; it is identical to `head`.
  - The block is stream-only.
  - `wr_ready = !full`.

## Structure
- Shared package `instr_feeder_pkg`:
  - `NOP_WORD` (32'h0000_0000, `sll $0,$0,0`).
  - Opcode and funct field position constants, shared with the decoder.
- One natural sub-module: `feeder_ram`, a DEPTH x DATA_W array with one write port and one read port.
- Pointer, count, mode and output register logic stays in `instr_feeder`.

## Test plan
- Reset, then idle with `enable` high for 3 cycles -> `instr_out` = 0, `instr_valid` = 0, `issued_cnt` = 0, `empty` = 1.
- Push 32'h2001_0004, 32'h2002_0002, 32'h0022_001A, 32'h0062_1818, 32'h0061_2022 back-to-back with `enable` high:
  - The five words appear in order, one per clock, starting one cycle after the first accept.
  - NOPs follow; `issued_cnt` = 5.
- Fill DEPTH = 16 words with `enable` low -> `full` = 1, `wr_ready` = 0, and a 17th push is not accepted.
  - Raise `enable` -> 16 words issue in order and `count` returns to 0.
- Issue 32'h2001_0004 and 32'h2002_0002, holding `stall` high for 2 cycles between them:
  - `instr_out` holds 32'h2001_0004 for 3 cycles in total.
  - `issued_cnt` advances by 1 only.
- With `INSTR_FEEDER_LOOP_EN`, load 3 words and set `loop` = 1:
  - The output sequence is A, B, C, A, B, C, ...; `count` stays at 3 and `wr_ready` = 0.
  - Drop `loop` -> A, B, C issue once more, followed by NOPs.
- Assert `rst_n` = 0 with 4 words queued, then release:
  - `count` = 0, `instr_out` = NOP.
  - No pre-reset word is ever issued.
